// File: rtl/programmable_clock_divider.sv
// ---------------------------------------------------------------------------
// programmable_clock_divider
//
// Purpose: generates the SPI serial clock from input_clock. Any even division
// ratio is supported: each half-period lasts (half_period_m1 + 1) input
// cycles. Every output is registered, so output_clock cannot glitch. A new
// ratio is only picked up at a trailing edge, so a period that has started
// always finishes with its original length. An optional burst length stops
// the clock after a fixed number of periods. lead_strobe and trail_strobe let
// the shift engine shift and sample in the input_clock domain.
//
// Ports:
//   input_clock     in   source clock
//   divider_reset   in   asynchronous, active-high reset
//   enable          in   request clock generation
//   cpol            in   idle level of output_clock
//   half_period_m1  in   half-period length in input cycles, minus 1
//   burst_len       in   periods to generate; 0 = free-run while enable
//   output_clock    out  divided clock, registered
//   lead_strobe     out  1-cycle pulse as output_clock leaves its idle level
//   trail_strobe    out  1-cycle pulse as output_clock returns to idle level
//   busy            out  high while running
//   done            out  1-cycle pulse when a burst completes
//   periods_done    out  full periods completed in the current run (wraps)
//   state_dbg       out  FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: enable is a level request, not a valid/ready pair. It is sampled
// in IDLE to start a run, and it is sampled at every leading decision in RUN.
// Dropping it never cuts a period short: the trailing half of the current
// period is always emitted before the block returns to IDLE.
// ---------------------------------------------------------------------------
module programmable_clock_divider #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 input_clock,
  input  logic                 divider_reset,
  input  logic                 enable,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] half_period_m1,
  input  logic [CNT_WIDTH-1:0] burst_len,
  output logic                 output_clock,
  output logic                 lead_strobe,
  output logic                 trail_strobe,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] periods_done,
  output logic                 state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] n_act;
  logic [CNT_WIDTH-1:0] burst_lat;
  logic                 cpol_lat;
  // One extra cycle at the start of a run. It places the first leading
  // edge N+2 cycles after enable is sampled; later half-periods are N+1.
  logic                 start_hold;
  logic [CNT_WIDTH-1:0] periods_next;
  logic                 burst_end;

  assign periods_next = periods_done + CNT_WIDTH'(1);
  assign burst_end    = (burst_lat != '0) && (periods_next == burst_lat);
  assign state_dbg    = (state == RUN);

  always_ff @(posedge input_clock or posedge divider_reset) begin
    if (divider_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      n_act        <= '0;
      burst_lat    <= '0;
      cpol_lat     <= 1'b0;
      start_hold   <= 1'b0;
      output_clock <= 1'b0;
      lead_strobe  <= 1'b0;
      trail_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      periods_done <= '0;
    end else begin
      lead_strobe  <= 1'b0;
      trail_strobe <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          // While idle the output follows cpol, one cycle late.
          output_clock <= cpol;
          if (enable) begin
            cpol_lat     <= cpol;
            n_act        <= half_period_m1;
            burst_lat    <= burst_len;
            cnt          <= '0;
            periods_done <= '0;
            start_hold   <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (start_hold) begin
            start_hold <= 1'b0;
          end else if (cnt != n_act) begin
            cnt <= cnt + DIV_WIDTH'(1);
          end else begin
            cnt <= '0;
            if (output_clock == cpol_lat) begin
              // Leading decision: only here may a run stop on enable=0,
              // which is what keeps every emitted pulse full width.
              if (!enable) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                output_clock <= ~output_clock;
                lead_strobe  <= 1'b1;
              end
            end else begin
              // Trailing edge: the period is complete. A new ratio is
              // loaded here, so it starts cleanly with the next period.
              output_clock <= ~output_clock;
              trail_strobe <= 1'b1;
              periods_done <= periods_next;
              n_act        <= half_period_m1;
              if (burst_end) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_programmable_clock_divider
//
// The reference model works at the level of edge times. For each run it
// computes the clock cycle of every leading and trailing edge from the
// half-period lengths. Each resulting event carries its cycle, the strobes,
// done, busy, the output level and periods_done, and goes into exp_q. A
// monitor compares every cycle in which the DUT raises a strobe or done
// against the head of the queue. Cycles are counted in posedges, and
// outputs are sampled at the following negedge.
// ---------------------------------------------------------------------------
module tb_programmable_clock_divider;

  localparam int EW = 45;  // {cycle[31:0], lead, trail, done, busy, oclk, pd[7:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        divider_reset;
  logic        enable;
  logic        cpol;
  logic [15:0] half_period_m1;
  logic [7:0]  burst_len;
  logic        output_clock;
  logic        lead_strobe;
  logic        trail_strobe;
  logic        busy;
  logic        done;
  logic [7:0]  periods_done;
  logic        state_dbg;

  programmable_clock_divider #(.DIV_WIDTH(16), .CNT_WIDTH(8)) dut (
    .input_clock    (clk),
    .divider_reset  (divider_reset),
    .enable         (enable),
    .cpol           (cpol),
    .half_period_m1 (half_period_m1),
    .burst_len      (burst_len),
    .output_clock   (output_clock),
    .lead_strobe    (lead_strobe),
    .trail_strobe   (trail_strobe),
    .busy           (busy),
    .done           (done),
    .periods_done   (periods_done),
    .state_dbg      (state_dbg)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [EW-1:0] mk_ev(int c, logic l, logic tr, logic d,
                                          logic b, logic o, int pd);
    return {c[31:0], l, tr, d, b, o, pd[7:0]};
  endfunction

  task automatic check_val(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, exp_v, cyc);
    end
  endtask

  // Reference model. Half-period p lasts H_p + 1 cycles. H_1 = h_first;
  // the ratio sampled at trail_1 (h_rest) governs every later period. The
  // first leading edge comes h_first + 2 cycles after the start edge t.
  // end_t is the done edge in burst mode. In free-run it is the leading
  // decision that sees enable low; last_lead is the final leading edge.
  task automatic push_run(input int t, input logic cp, input int h_first,
                          input int h_rest, input int burst, input int periods,
                          output int end_t, output int last_lead);
    int lead_t, trail_t, h;
    logic last;
    h      = h_first;
    lead_t = t + h_first + 2;
    end_t  = 0;
    last_lead = lead_t;
    for (int p = 1; p <= periods; p++) begin
      exp_q.push_back(mk_ev(lead_t, 1'b1, 1'b0, 1'b0, 1'b1, ~cp, (p - 1) % 256));
      last_lead = lead_t;
      trail_t = lead_t + h + 1;
      last = (burst != 0) && (p == burst);
      exp_q.push_back(mk_ev(trail_t, 1'b0, 1'b1, last, ~last, cp, p % 256));
      h      = h_rest;
      lead_t = trail_t + h + 1;
      end_t  = (burst != 0) ? trail_t : lead_t;
    end
  endtask

  // monitor
  task automatic monitor();
    logic [EW-1:0] got, e;
    forever begin
      @(negedge clk);
      got = mk_ev(cyc, lead_strobe, trail_strobe, done, busy, output_clock,
                  int'(periods_done));
      while (exp_q.size() > 0 && int'(exp_q[0][44:13]) < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event expected=%h at cycle %0d", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (lead_strobe || trail_strobe || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got=%h at cycle %0d", got, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== got) begin
            failures++;
            $display("FAIL event got=%h expected=%h at cycle %0d", got, e, cyc);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic idle_gap(input int n);
    logic x;
    for (int i = 0; i < n; i++) begin
      x = 1'($urandom_range(0, 1));
      cpol = x;
      @(negedge clk);
      check_val("idle_follows_cpol", int'(output_clock), int'(x));
    end
  endtask

  // One complete run, called at a negedge. Latched inputs are scrambled once
  // the run starts, and the ratio changes one cycle into the first high phase.
  task automatic do_run(input logic cp, input int n_first, input int n_rest,
                        input int burst, input int periods);
    int t, e, l, chg, drop;
    cpol = cp;
    half_period_m1 = 16'(n_first);
    burst_len = 8'(burst);
    enable = 1'b1;
    t = cyc + 1;
    push_run(t, cp, n_first, n_rest, burst, periods, e, l);
    chg  = (n_first == 0) ? t : t + n_first + 3;
    drop = (burst != 0) ? e : l;
    while (cyc < e + 1) begin
      @(negedge clk);
      if (cyc == t) begin
        cpol = 1'($urandom_range(0, 1));
        burst_len = 8'($urandom_range(0, 255));
      end
      if (cyc == chg) half_period_m1 = 16'(n_rest);
      if (cyc == drop) begin
        enable = 1'b0;
        cpol = cp;
      end
      if (cyc == e) check_val("busy_low_at_end", int'(busy), 0);
    end
    check_val("idle_level_after_run", int'(output_clock), int'(cp));
    check_val("idle_busy_after_run", int'(busy), 0);
  endtask

  initial begin
    int t, e1, l1, e2, l2;
    divider_reset = 1'b1;
    enable = 1'b0;
    cpol = 1'b1;
    half_period_m1 = '0;
    burst_len = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_val("reset_output_clock", int'(output_clock), 0);
    check_val("reset_lead", int'(lead_strobe), 0);
    check_val("reset_trail", int'(trail_strobe), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_periods_done", int'(periods_done), 0);
    check_val("reset_state", int'(state_dbg), 0);
    divider_reset = 1'b0;
    idle_gap(2);

    // cpol=0, N=3: first lead 5 cycles after the enable edge, period of 8
    do_run(1'b0, 3, 3, 0, 3);
    idle_gap(2);
    // cpol=1, N=0, 4-period burst
    do_run(1'b1, 0, 0, 4, 4);
    idle_gap(2);
    // ratio 2 -> 5 during the first high phase
    do_run(1'b0, 2, 5, 0, 3);
    idle_gap(2);
    // N=1, enable dropped right after the second lead_strobe
    do_run(1'b0, 1, 1, 0, 2);
    idle_gap(2);

    // enable still high when a burst completes: one IDLE cycle, then restart
    cpol = 1'b0;
    half_period_m1 = 16'd1;
    burst_len = 8'd2;
    enable = 1'b1;
    t = cyc + 1;
    push_run(t, 1'b0, 1, 1, 2, 2, e1, l1);
    push_run(e1 + 1, 1'b0, 1, 1, 1, 1, e2, l2);
    while (cyc < e2 + 1) begin
      @(negedge clk);
      if (cyc == e1) begin
        burst_len = 8'd1;
        check_val("restart_idle_busy", int'(busy), 0);
      end
      if (cyc == e1 + 1) check_val("restart_busy", int'(busy), 1);
      if (cyc == e2) begin
        enable = 1'b0;
        check_val("restart_end_busy", int'(busy), 0);
      end
    end
    check_val("restart_idle_level", int'(output_clock), 0);
    idle_gap(2);

    // asynchronous reset while output is high and cnt=2 in period 2
    cpol = 1'b0;
    half_period_m1 = 16'd3;
    burst_len = 8'd0;
    enable = 1'b1;
    t = cyc + 1;
    push_run(t, 1'b0, 3, 3, 0, 2, e1, l1);
    while (cyc < l1 + 2) @(negedge clk);
    check_val("pre_reset_output", int'(output_clock), 1);
    check_val("pre_reset_periods", int'(periods_done), 1);
    #1 divider_reset = 1'b1;
    #1;
    check_val("async_reset_output", int'(output_clock), 0);
    check_val("async_reset_busy", int'(busy), 0);
    check_val("async_reset_periods", int'(periods_done), 0);
    check_val("async_reset_pending", exp_q.size(), 1);
    exp_q.delete();
    enable = 1'b0;
    @(negedge clk);
    divider_reset = 1'b0;
    idle_gap(2);

    // free-run wrap of periods_done after 256 periods, no done pulse
    do_run(1'b0, 0, 0, 0, 257);
    idle_gap(2);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      int nf, nr, b, np;
      nf = $urandom_range(0, 4);
      nr = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        b = $urandom_range(1, 5);
        np = b;
      end else begin
        b = 0;
        np = $urandom_range(1, 4);
      end
      do_run(1'($urandom_range(0, 1)), nf, nr, b, np);
      idle_gap($urandom_range(1, 3));
    end

    repeat (4) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
